// File: rtl/trigger_latency_meter.sv
// Trigger latency meter: counts clock cycles between a start edge and a stop edge.
// Both trigger inputs share an identical synchronizer/edge path so the result is unbiased.
module trigger_latency_meter #(
    parameter int SYNC_STAGES = 3,
    parameter int CNT_BITS    = 32,
    parameter int AUTO_REARM  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_in,
    input  logic                stop_in,
    input  logic [1:0]          start_edge,
    input  logic [1:0]          stop_edge,
    input  logic [CNT_BITS-1:0] timeout_cycles,
    input  logic                arm,
    input  logic                disarm,
    output logic                armed,
    output logic                busy,
    output logic [CNT_BITS-1:0] result_cycles,
    output logic                result_timeout,
    output logic                result_valid,
    input  logic                result_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COUNTING,
        S_DONE
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] start_sync;
    logic [SYNC_STAGES-1:0] stop_sync;
    logic                   start_prev;
    logic                   stop_prev;
    logic                   start_pulse;
    logic                   stop_pulse;

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] tmo_q, tmo_d;
    logic [CNT_BITS-1:0] res_q, res_d;
    logic                rto_q, rto_d;
    logic                armed_d;
    logic                busy_d;
    logic                valid_d;

    // Select which transitions of a synchronized level count as an edge.
    function automatic logic edge_pulse(
        input logic [1:0] sel,
        input logic       cur,
        input logic       prev
    );
        logic hit;
        hit = 1'b0;
        case (sel)
            2'b00:   hit = cur & ~prev;
            2'b01:   hit = ~cur & prev;
            2'b10:   hit = cur ^ prev;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Synchronizer chains plus one edge-history flop per trigger input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync <= '0;
            stop_sync  <= '0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
        end else begin
            start_sync <= {start_sync[SYNC_STAGES-2:0], start_in};
            stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stop_in};
            start_prev <= start_sync[SYNC_STAGES-1];
            stop_prev  <= stop_sync[SYNC_STAGES-1];
        end
    end

    assign start_pulse = edge_pulse(start_edge, start_sync[SYNC_STAGES-1],
                                    start_prev);
    assign stop_pulse  = edge_pulse(stop_edge, stop_sync[SYNC_STAGES-1],
                                    stop_prev);

    // State, counter, latched timeout and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            res_q        <= '0;
            rto_q        <= 1'b0;
            armed        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            res_q        <= res_d;
            rto_q        <= rto_d;
            armed        <= armed_d;
            busy         <= busy_d;
            result_valid <= valid_d;
        end
    end

    // Next-state and datapath: stop beats timeout, disarm beats both.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        res_d   = res_q;
        rto_d   = rto_q;
        unique case (state_q)
            S_IDLE: begin
                if (arm && !disarm) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (disarm) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (start_pulse) begin
                    state_d = S_COUNTING;
                    cnt_d   = CNT_ONE;
                    tmo_d   = timeout_cycles;
                    rto_d   = 1'b0;
                end
            end
            S_COUNTING: begin
                if (disarm) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (stop_pulse) begin
                    state_d = S_DONE;
                    res_d   = cnt_q;
                    rto_d   = 1'b0;
                end else if (tmo_q != '0 && cnt_q == tmo_q) begin
                    state_d = S_DONE;
                    res_d   = tmo_q;
                    rto_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = (AUTO_REARM != 0) ? S_ARMED : S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are registered decodes of the state being entered.
    always_comb begin
        armed_d = (state_d == S_ARMED);
        busy_d  = (state_d == S_ARMED) || (state_d == S_COUNTING);
        valid_d = (state_d == S_DONE);
    end

    assign result_cycles  = res_q;
    assign result_timeout = rto_q;

endmodule
